// File: rtl/adbg_axi_pkg.sv
// Shared constants and FSM state type for the debug AXI slave memory.
package adbg_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WR_DATA = 2'b01,
        WR_RESP = 2'b10,
        RD_DATA = 2'b11
    } state_e;

endpackage

// File: rtl/adbg_axi_slave_addr_gen.sv
// Per-beat address helper: next burst address, window hit test and word index.
module adbg_axi_slave_addr_gen
    import adbg_axi_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        DEPTH          = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1000_0000,
    localparam int                       IDX_W          = $clog2(DEPTH)
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]                burst_i,
    output logic [AXI_ADDR_WIDTH-1:0] next_addr_o,
    output logic                      in_range_o,
    output logic [IDX_W-1:0]          word_idx_o
);

    localparam int LSB = $clog2(AXI_DATA_WIDTH / 8);
    localparam int HI  = LSB + IDX_W;
    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);

    logic unused_lsb_s;

    // BASE_ADDR is aligned to the window size, so a hit is an upper-bit match.
    assign in_range_o   = (addr_i[AXI_ADDR_WIDTH-1:HI] == BASE_ADDR[AXI_ADDR_WIDTH-1:HI]);
    assign word_idx_o   = addr_i[HI-1:LSB];
    assign unused_lsb_s = ^addr_i[LSB-1:0];

    // FIXED holds the address; everything else steps one beat (no 4 KiB wrap).
    always_comb begin
        next_addr_o = addr_i;
        if (burst_i == BURST_FIXED) begin
            next_addr_o = addr_i;
        end else begin
            next_addr_o = addr_i + BEAT_BYTES;
        end
    end

endmodule

// File: rtl/adbg_axi_slave_mem.sv
// AXI4 slave backed by a flop array; serves one INCR/FIXED burst at a time.
module adbg_axi_slave_mem
    import adbg_axi_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        AXI_USER_WIDTH = 6,
    parameter int                        AXI_ID_WIDTH   = 3,
    parameter int                        DEPTH          = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1000_0000
) (
    input  logic                        axi_aclk,
    input  logic                        axi_areset,
    input  logic                        axi_slave_aw_valid,
    output logic                        axi_slave_aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr,
    input  logic [7:0]                  axi_slave_aw_len,
    input  logic [2:0]                  axi_slave_aw_size,
    input  logic [1:0]                  axi_slave_aw_burst,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id,
    input  logic [2:0]                  axi_slave_aw_prot,
    input  logic [3:0]                  axi_slave_aw_region,
    input  logic                        axi_slave_aw_lock,
    input  logic [3:0]                  axi_slave_aw_cache,
    input  logic [3:0]                  axi_slave_aw_qos,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_aw_user,
    input  logic                        axi_slave_w_valid,
    output logic                        axi_slave_w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb,
    input  logic                        axi_slave_w_last,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_w_user,
    output logic                        axi_slave_b_valid,
    input  logic                        axi_slave_b_ready,
    output logic [1:0]                  axi_slave_b_resp,
    output logic [AXI_ID_WIDTH-1:0]     axi_slave_b_id,
    output logic [AXI_USER_WIDTH-1:0]   axi_slave_b_user,
    input  logic                        axi_slave_ar_valid,
    output logic                        axi_slave_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr,
    input  logic [7:0]                  axi_slave_ar_len,
    input  logic [2:0]                  axi_slave_ar_size,
    input  logic [1:0]                  axi_slave_ar_burst,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id,
    input  logic [2:0]                  axi_slave_ar_prot,
    input  logic [3:0]                  axi_slave_ar_region,
    input  logic                        axi_slave_ar_lock,
    input  logic [3:0]                  axi_slave_ar_cache,
    input  logic [3:0]                  axi_slave_ar_qos,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_ar_user,
    output logic                        axi_slave_r_valid,
    input  logic                        axi_slave_r_ready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_slave_r_data,
    output logic [1:0]                  axi_slave_r_resp,
    output logic                        axi_slave_r_last,
    output logic [AXI_ID_WIDTH-1:0]     axi_slave_r_id,
    output logic [AXI_USER_WIDTH-1:0]   axi_slave_r_user
);

    localparam int         STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int         LSB      = $clog2(STRB_W);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [2:0] SIZE_NAT = 3'(LSB);

    state_e                    state_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                cnt_q;
    logic [1:0]                burst_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic                      burst_err_q;
    logic                      sticky_err_q;
    logic                      out_of_reset_q;
    logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AXI_ADDR_WIDTH-1:0] next_addr_d;
    logic                      in_range_s;
    logic [IDX_W-1:0]          word_idx_s;
    logic                      beat_err_s;
    logic                      wr_en_s;
    logic                      unused_s;

    function automatic logic burst_err_f(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_NAT) || (burst == BURST_WRAP);
    endfunction

    adbg_axi_slave_addr_gen #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .DEPTH          (DEPTH),
        .BASE_ADDR      (BASE_ADDR)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr_d),
        .in_range_o  (in_range_s),
        .word_idx_o  (word_idx_s)
    );

    assign beat_err_s = burst_err_q | ~in_range_s;
    assign wr_en_s    = axi_slave_w_valid & axi_slave_w_ready & in_range_s & ~burst_err_q;

    assign axi_slave_aw_ready = out_of_reset_q & (state_q == IDLE);
    assign axi_slave_ar_ready = out_of_reset_q & (state_q == IDLE) & ~axi_slave_aw_valid;
    assign axi_slave_w_ready  = (state_q == WR_DATA);
    assign axi_slave_b_valid  = (state_q == WR_RESP);
    assign axi_slave_b_resp   = (burst_err_q | sticky_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi_slave_b_id     = id_q;
    assign axi_slave_b_user   = '0;
    assign axi_slave_r_valid  = (state_q == RD_DATA);
    assign axi_slave_r_data   = beat_err_s ? '0 : mem_q[word_idx_s];
    assign axi_slave_r_resp   = beat_err_s ? RESP_SLVERR : RESP_OKAY;
    assign axi_slave_r_last   = (cnt_q == 8'd0);
    assign axi_slave_r_id     = id_q;
    assign axi_slave_r_user   = '0;

    assign unused_s = ^{axi_slave_aw_prot, axi_slave_aw_region, axi_slave_aw_lock, axi_slave_aw_cache,
                        axi_slave_aw_qos, axi_slave_aw_user, axi_slave_w_user, axi_slave_ar_prot,
                        axi_slave_ar_region, axi_slave_ar_lock, axi_slave_ar_cache, axi_slave_ar_qos,
                        axi_slave_ar_user};

    // Transaction FSM with its address, beat counter and error latches.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            cnt_q          <= 8'd0;
            burst_q        <= 2'b00;
            id_q           <= '0;
            burst_err_q    <= 1'b0;
            sticky_err_q   <= 1'b0;
            out_of_reset_q <= 1'b0;
        end else begin
            out_of_reset_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (axi_slave_aw_valid && axi_slave_aw_ready) begin
                        addr_q       <= axi_slave_aw_addr;
                        cnt_q        <= axi_slave_aw_len;
                        burst_q      <= axi_slave_aw_burst;
                        id_q         <= axi_slave_aw_id;
                        burst_err_q  <= burst_err_f(axi_slave_aw_size, axi_slave_aw_burst);
                        sticky_err_q <= 1'b0;
                        state_q      <= WR_DATA;
                    end else if (axi_slave_ar_valid && axi_slave_ar_ready) begin
                        addr_q      <= axi_slave_ar_addr;
                        cnt_q       <= axi_slave_ar_len;
                        burst_q     <= axi_slave_ar_burst;
                        id_q        <= axi_slave_ar_id;
                        burst_err_q <= burst_err_f(axi_slave_ar_size, axi_slave_ar_burst);
                        state_q     <= RD_DATA;
                    end
                end
                WR_DATA: begin
                    if (axi_slave_w_valid) begin
                        addr_q <= next_addr_d;
                        cnt_q  <= cnt_q - 8'd1;
                        // w_last must coincide exactly with the final counted beat.
                        if (!in_range_s || (axi_slave_w_last != (cnt_q == 8'd0))) begin
                            sticky_err_q <= 1'b1;
                        end
                        if (axi_slave_w_last) begin
                            state_q <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi_slave_b_ready) begin
                        state_q <= IDLE;
                    end
                end
                RD_DATA: begin
                    if (axi_slave_r_ready) begin
                        if (cnt_q == 8'd0) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q  <= cnt_q - 8'd1;
                            addr_q <= next_addr_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage array with byte-lane write enables.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_slave_w_strb[b]) begin
                    mem_q[word_idx_s][b*8 +: 8] <= axi_slave_w_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_adbg_axi_slave_mem.sv
// Scoreboard bench: byte-level memory model predicts B/R responses, a negedge monitor checks them.
module tb_adbg_axi_slave_mem;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] SPAN  = 32'd2048;
    localparam logic [1:0]  FIXED = 2'b00;
    localparam logic [1:0]  INCR  = 2'b01;
    localparam logic [1:0]  WRAP  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        aw_valid, aw_ready, aw_lock;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size, aw_prot, aw_id;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_region, aw_cache, aw_qos;
    logic [5:0]  aw_user;
    logic        w_valid, w_ready, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic [5:0]  w_user;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic [2:0]  b_id;
    logic [5:0]  b_user;
    logic        ar_valid, ar_ready, ar_lock;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size, ar_prot, ar_id;
    logic [1:0]  ar_burst;
    logic [3:0]  ar_region, ar_cache, ar_qos;
    logic [5:0]  ar_user;
    logic        r_valid, r_ready, r_last;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [2:0]  r_id;
    logic [5:0]  r_user;

    adbg_axi_slave_mem dut (
        .axi_aclk(clk), .axi_areset(rst),
        .axi_slave_aw_valid(aw_valid), .axi_slave_aw_ready(aw_ready), .axi_slave_aw_addr(aw_addr),
        .axi_slave_aw_len(aw_len), .axi_slave_aw_size(aw_size), .axi_slave_aw_burst(aw_burst),
        .axi_slave_aw_id(aw_id), .axi_slave_aw_prot(aw_prot), .axi_slave_aw_region(aw_region),
        .axi_slave_aw_lock(aw_lock), .axi_slave_aw_cache(aw_cache), .axi_slave_aw_qos(aw_qos),
        .axi_slave_aw_user(aw_user),
        .axi_slave_w_valid(w_valid), .axi_slave_w_ready(w_ready), .axi_slave_w_data(w_data),
        .axi_slave_w_strb(w_strb), .axi_slave_w_last(w_last), .axi_slave_w_user(w_user),
        .axi_slave_b_valid(b_valid), .axi_slave_b_ready(b_ready), .axi_slave_b_resp(b_resp),
        .axi_slave_b_id(b_id), .axi_slave_b_user(b_user),
        .axi_slave_ar_valid(ar_valid), .axi_slave_ar_ready(ar_ready), .axi_slave_ar_addr(ar_addr),
        .axi_slave_ar_len(ar_len), .axi_slave_ar_size(ar_size), .axi_slave_ar_burst(ar_burst),
        .axi_slave_ar_id(ar_id), .axi_slave_ar_prot(ar_prot), .axi_slave_ar_region(ar_region),
        .axi_slave_ar_lock(ar_lock), .axi_slave_ar_cache(ar_cache), .axi_slave_ar_qos(ar_qos),
        .axi_slave_ar_user(ar_user),
        .axi_slave_r_valid(r_valid), .axi_slave_r_ready(r_ready), .axi_slave_r_data(r_data),
        .axi_slave_r_resp(r_resp), .axi_slave_r_last(r_last), .axi_slave_r_id(r_id),
        .axi_slave_r_user(r_user)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] resp; logic [2:0] id; } b_exp_t;
    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [2:0] id; } r_exp_t;

    int          tests = 0;
    int          fails = 0;
    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    b_exp_t      be_m;
    r_exp_t      re_m;
    logic [7:0]  mdl [2048];
    logic [63:0] wdata_a [16];
    logic [7:0]  wstrb_a [16];
    bit          ar_block_chk = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no response within cycle bound", name);
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int k);
        return (burst == FIXED) ? a : a + 32'(k * 8);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + SPAN);
    endfunction

    function automatic bit bad_burst(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'd3) || (burst == WRAP);
    endfunction

    function automatic logic [63:0] mdl_word(input logic [31:0] a);
        logic [63:0] w;
        int          off;
        off = int'((a - BASE) & 32'hFFFF_FFF8);
        for (int b = 0; b < 8; b++) w[b*8 +: 8] = mdl[off + b];
        return w;
    endfunction

    // Monitor: compare every presented B/R against the head of its expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (ar_block_chk) begin
                check("ar_ready_blocked", 64'(ar_ready), 64'd0);
                if (b_valid && b_ready) ar_block_chk = 1'b0;
            end
            if (b_valid && b_ready) begin
                if (b_q.size() == 0) begin
                    timeout_fail("b_unexpected");
                end else begin
                    be_m = b_q.pop_front();
                    check("b_resp", 64'(b_resp), 64'(be_m.resp));
                    check("b_id", 64'(b_id), 64'(be_m.id));
                end
            end
            if (r_valid) begin
                if (r_q.size() == 0) begin
                    timeout_fail("r_unexpected");
                end else begin
                    re_m = r_q[0];
                    check("r_data", r_data, re_m.data);
                    check("r_resp", 64'(r_resp), 64'(re_m.resp));
                    check("r_last", 64'(r_last), 64'(re_m.last));
                    check("r_id", 64'(r_id), 64'(re_m.id));
                    if (r_ready) void'(r_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hs_wait(input int ch, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((ch == 0 && aw_ready) || (ch == 1 && ar_ready) || (ch == 2 && w_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [2:0] id, input int nbeats);
        bit          err, ok;
        b_exp_t      e;
        logic [31:0] ba;
        int          off;
        err = bad_burst(size, burst) || (nbeats != int'(len) + 1);
        for (int k = 0; k < nbeats; k++) begin
            ba = beat_addr(a, burst, k);
            if (!in_rng(ba)) begin
                err = 1'b1;
            end else if (!bad_burst(size, burst)) begin
                off = int'((ba - BASE) & 32'hFFFF_FFF8);
                for (int b = 0; b < 8; b++)
                    if (wstrb_a[k][b]) mdl[off + b] = wdata_a[k][b*8 +: 8];
            end
        end
        e.resp = err ? 2'b10 : 2'b00;
        e.id   = id;
        b_q.push_back(e);
        aw_addr = a; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id;
        aw_valid = 1'b1;
        hs_wait(0, ok);
        aw_valid = 1'b0;
        if (!ok) timeout_fail("aw_handshake");
        for (int k = 0; k < nbeats; k++) begin
            w_data = wdata_a[k]; w_strb = wstrb_a[k]; w_last = (k == nbeats - 1);
            w_valid = 1'b1;
            hs_wait(2, ok);
            w_valid = 1'b0;
            if (!ok) timeout_fail("w_handshake");
            if ($urandom_range(0, 3) == 0) tick();
        end
        for (int n = 0; n < 200 && b_q.size() != 0; n++) tick();
        if (b_q.size() != 0) begin
            timeout_fail("b_wait");
            b_q.delete();
        end
    endtask

    task automatic push_rd_exp(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [2:0] id);
        r_exp_t      e;
        logic [31:0] ba;
        for (int k = 0; k <= int'(len); k++) begin
            ba     = beat_addr(a, burst, k);
            e.resp = (bad_burst(size, burst) || !in_rng(ba)) ? 2'b10 : 2'b00;
            e.data = (e.resp == 2'b00) ? mdl_word(ba) : 64'd0;
            e.last = (k == int'(len));
            e.id   = id;
            r_q.push_back(e);
        end
    endtask

    task automatic reset_seq(input bit mid);
        if (mid) begin
            r_ready = 1'b0;
            #2;
        end
        rst = 1'b1;
        #1;
        check("rst_r_valid", 64'(r_valid), 64'd0);
        check("rst_b_valid", 64'(b_valid), 64'd0);
        check("rst_w_ready", 64'(w_ready), 64'd0);
        check("rst_aw_ready", 64'(aw_ready), 64'd0);
        check("rst_ar_ready", 64'(ar_ready), 64'd0);
        r_q.delete();
        b_q.delete();
        foreach (mdl[i]) mdl[i] = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rel_aw_ready_low", 64'(aw_ready), 64'd0);
        tick();
        check("rel_aw_ready_high", 64'(aw_ready), 64'd1);
        r_ready = 1'b1;
    endtask

    // mode: 0 always ready, 1 random backpressure, 2 stall beat 1 for 5 cycles, 3 reset on beat 2
    task automatic drain_r(input int mode, input int total);
        int stall = 0;
        int done;
        for (int n = 0; n < 400 && r_q.size() != 0; n++) begin
            done = total - r_q.size();
            if (mode == 3 && done == 2) begin
                reset_seq(1'b1);
                return;
            end else if (mode == 1) begin
                r_ready = ($urandom_range(0, 2) != 0);
            end else if (mode == 2 && done == 1 && stall < 5) begin
                r_ready = 1'b0;
                stall++;
            end else begin
                r_ready = 1'b1;
            end
            tick();
        end
        r_ready = 1'b1;
        if (r_q.size() != 0) begin
            timeout_fail("r_wait");
            r_q.delete();
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [2:0] id, input int mode);
        bit ok;
        push_rd_exp(a, len, size, burst, id);
        ar_addr = a; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id;
        ar_valid = 1'b1;
        hs_wait(1, ok);
        ar_valid = 1'b0;
        if (!ok) timeout_fail("ar_handshake");
        drain_r(mode, int'(len) + 1);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        bit          ok;
        rst = 1'b1;
        aw_valid = 1'b0; aw_addr = 32'd0; aw_len = 8'd0; aw_size = 3'd3; aw_burst = INCR; aw_id = 3'd0;
        aw_prot = 3'd0; aw_region = 4'd0; aw_lock = 1'b0; aw_cache = 4'd0; aw_qos = 4'd0; aw_user = 6'd0;
        w_valid = 1'b0; w_data = 64'd0; w_strb = 8'd0; w_last = 1'b0; w_user = 6'd0;
        b_ready = 1'b1;
        ar_valid = 1'b0; ar_addr = 32'd0; ar_len = 8'd0; ar_size = 3'd3; ar_burst = INCR; ar_id = 3'd0;
        ar_prot = 3'd0; ar_region = 4'd0; ar_lock = 1'b0; ar_cache = 4'd0; ar_qos = 4'd0; ar_user = 6'd0;
        r_ready = 1'b1;
        #3;
        reset_seq(1'b0);

        wdata_a[0] = 64'hDEADBEEF_CAFEF00D; wstrb_a[0] = 8'hFF;
        do_write(BASE + 32'h8, 8'd0, 3'd3, INCR, 3'd3, 1);
        do_read(BASE + 32'h8, 8'd0, 3'd3, INCR, 3'd5, 0);

        wdata_a[0] = {16{4'h1}}; wdata_a[1] = {16{4'h2}}; wdata_a[2] = {16{4'h3}}; wdata_a[3] = {16{4'h4}};
        wstrb_a[0] = 8'hFF; wstrb_a[1] = 8'hFF; wstrb_a[2] = 8'h0F; wstrb_a[3] = 8'hFF;
        do_write(BASE, 8'd3, 3'd3, INCR, 3'd2, 4);
        do_read(BASE, 8'd3, 3'd3, INCR, 3'd4, 1);

        // AW and AR raised together: the write goes first, the read waits for B
        push_rd_exp(BASE + 32'h100, 8'd1, 3'd3, INCR, 3'd1);
        ar_addr = BASE + 32'h100; ar_len = 8'd1; ar_size = 3'd3; ar_burst = INCR; ar_id = 3'd1;
        ar_valid = 1'b1;
        ar_block_chk = 1'b1;
        wdata_a[0] = 64'h0123_4567_89AB_CDEF; wstrb_a[0] = 8'hFF;
        do_write(BASE + 32'h40, 8'd0, 3'd3, INCR, 3'd6, 1);
        hs_wait(1, ok);
        ar_valid = 1'b0;
        if (!ok) timeout_fail("ar_after_write");
        drain_r(0, 2);

        do_read(BASE + 32'h800, 8'd1, 3'd3, INCR, 3'd0, 0);
        wdata_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrb_a[0] = 8'hFF;
        do_write(BASE + 32'h800, 8'd0, 3'd3, INCR, 3'd7, 1);
        do_read(BASE, 8'd0, 3'd3, INCR, 3'd0, 0);
        do_write(BASE + 32'h20, 8'd0, 3'd2, INCR, 3'd1, 1);
        do_read(BASE + 32'h20, 8'd0, 3'd3, INCR, 3'd1, 0);
        do_read(BASE + 32'h8, 8'd0, 3'd2, INCR, 3'd2, 0);
        do_read(BASE, 8'd1, 3'd3, WRAP, 3'd2, 0);

        do_read(BASE, 8'd3, 3'd3, INCR, 3'd3, 2);
        do_read(BASE + 32'h8, 8'd2, 3'd3, FIXED, 3'd4, 0);

        wdata_a[0] = 64'hA5A5_A5A5_5A5A_5A5A; wdata_a[1] = 64'h1; wstrb_a[0] = 8'hFF; wstrb_a[1] = 8'hFF;
        do_write(BASE + 32'h7F8, 8'd1, 3'd3, INCR, 3'd5, 2);
        do_read(BASE + 32'h7F8, 8'd1, 3'd3, INCR, 3'd5, 0);
        wdata_a[0] = 64'h7777_0000_7777_0000; wstrb_a[0] = 8'hF0;
        do_write(BASE + 32'h60, 8'd2, 3'd3, INCR, 3'd6, 1);
        do_read(BASE + 32'h60, 8'd0, 3'd3, INCR, 3'd6, 0);

        for (int t = 0; t < 60; t++) begin
            a = BASE + (32'($urandom_range(0, 255)) << 3);
            case ($urandom_range(0, 9))
                0: a = BASE + SPAN - 32'd16;
                1: a = BASE - 32'd24;
                2: a = BASE + SPAN + (32'($urandom_range(0, 15)) << 3);
                default: a = a;
            endcase
            len   = 8'($urandom_range(0, 7));
            burst = ($urandom_range(0, 9) == 0) ? WRAP : (($urandom_range(0, 3) == 0) ? FIXED : INCR);
            size  = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3;
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < 16; k++) begin
                    wdata_a[k] = {$urandom, $urandom};
                    wstrb_a[k] = 8'($urandom);
                end
                do_write(a, len, size, burst, 3'($urandom), int'(len) + 1);
            end else begin
                do_read(a, len, size, burst, 3'($urandom), 1);
            end
        end

        wdata_a[0] = 64'h0BAD_F00D_0BAD_F00D; wstrb_a[0] = 8'hFF;
        do_write(BASE + 32'h10, 8'd0, 3'd3, INCR, 3'd1, 1);
        do_read(BASE, 8'd3, 3'd3, INCR, 3'd2, 3);
        tick();
        tick();
        do_read(BASE + 32'h10, 8'd0, 3'd3, INCR, 3'd3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
